// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read memory port between instruction fetch and
// load/store traffic, with a streak limit on data priority and an EBREAK halt.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              halt_req,
    input  logic              halt_clr,
    output logic              halted,
    output logic              isInst,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic { RUN, HALT } state_t;
    typedef enum logic [1:0] { P_NONE, P_IF, P_D } pend_t;

    state_t            state, state_nx;
    pend_t             pend, pend_nx;
    logic [SW-1:0]     streak, streak_nx;
    logic [DATA_W-1:0] if_hold, d_hold;
    logic              fetch_wins;

    always_comb begin
        state_nx   = state;
        pend_nx    = P_NONE;
        streak_nx  = streak;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fetch_wins = if_req && (state == RUN) && (streak == STREAK_MAX);

        if (halt_req)
            state_nx = HALT;
        else if (halt_clr)
            state_nx = RUN;

        if (!rst) begin
            if (d_req && !fetch_wins)
                d_gnt = 1'b1;
            else if (if_req && state == RUN)
                if_gnt = 1'b1;
        end

        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (!d_we)
                pend_nx = P_D;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
            pend_nx  = P_IF;
        end

        // Streak only measures how long a waiting fetch has been starved by data.
        if (!if_req || if_gnt)
            streak_nx = '0;
        else if (state == RUN && d_gnt && streak != STREAK_MAX)
            streak_nx = streak + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pend    <= P_NONE;
            streak  <= '0;
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            state  <= state_nx;
            pend   <= pend_nx;
            streak <= streak_nx;
            if (pend == P_IF)
                if_hold <= mem_rdata;
            if (pend == P_D)
                d_hold <= mem_rdata;
        end
    end

    // Read data is forwarded from the memory in its valid cycle, then held.
    assign if_rvalid = (pend == P_IF);
    assign d_rvalid  = (pend == P_D);
    assign if_rdata  = if_rvalid ? mem_rdata : if_hold;
    assign d_rdata   = d_rvalid ? mem_rdata : d_hold;
    assign isInst    = if_rvalid;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        halt_req, halt_clr, halted, isInst;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_halt;
    int          m_streak;
    int          m_pend;      // 0 none, 1 fetch, 2 load
    logic [31:0] m_ird, m_drd;
    bit          last_i, last_d;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .halt_req(halt_req), .halt_clr(halt_clr), .halted(halted), .isInst(isInst),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_streak = 0; m_pend = 0; m_ird = '0; m_drd = '0;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle();
        bit ed, ei;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        #2;
        if (rst) model_reset();
        ed = 0; ei = 0;
        if (!rst) begin
            if (d_req && if_req && !m_halt)
                if (m_streak == MAX) ei = 1; else ed = 1;
            else if (d_req)
                ed = 1;
            else if (if_req && !m_halt)
                ei = 1;
        end
        e_addr  = ed ? d_addr  : (ei ? if_addr : 32'h0);
        e_wdata = ed ? d_wdata : 32'h0;
        e_be    = ed ? d_be    : (ei ? 4'hF : 4'h0);
        chk("if_gnt",    if_gnt,    ei);
        chk("d_gnt",     d_gnt,     ed);
        chk("mem_en",    mem_en,    ed | ei);
        chk("mem_we",    mem_we,    ed & d_we);
        chk("mem_be",    mem_be,    e_be);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_rvalid", if_rvalid, m_pend == 1);
        chk("isInst",    isInst,    m_pend == 1);
        chk("d_rvalid",  d_rvalid,  m_pend == 2);
        chk("if_rdata",  if_rdata,  (m_pend == 1) ? mem_rdata : m_ird);
        chk("d_rdata",   d_rdata,   (m_pend == 2) ? mem_rdata : m_drd);
        chk("halted",    halted,    m_halt);
        last_i = ei; last_d = ed;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_pend == 1) m_ird = mem_rdata;
            if (m_pend == 2) m_drd = mem_rdata;
            m_pend = ei ? 1 : ((ed && !d_we) ? 2 : 0);
            if (!if_req || ei)            m_streak = 0;
            else if (!m_halt && ed)       m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
            if (halt_req)                 m_halt = 1;
            else if (halt_clr)            m_halt = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_be = 4'hF;
        d_addr = 32'h80; d_wdata = '0; halt_req = 0; halt_clr = 0; mem_rdata = 32'h1234_5678;
        last_i = 0; last_d = 0;
        model_reset();
        @(negedge clk);

        // Reset holds everything quiet even with requests present
        cycle(); cycle();
        rst = 0; if_req = 0; d_req = 0;
        cycle(); cycle();
        if_req = 1; if_addr = 32'h200;
        #1 chk("rst_mid_gnt", if_gnt, 1'b1);
        cycle();
        rst = 1; if_req = 0;
        #1 chk("rst_mid_rvalid", if_rvalid, 1'b0);
        cycle();
        rst = 0;
        #1 chk("rst_post_rvalid", if_rvalid, 1'b0);
        cycle();
        d_req = 1; d_we = 0; d_addr = 32'h300;
        #1 chk("rst_first_gnt", d_gnt, 1'b1);
        cycle();
        d_req = 0;
        #1 chk("rst_first_rvalid", d_rvalid, 1'b1);
        cycle();

        // Fetch only
        if_req = 1; if_addr = 32'h100;
        #1 chk("fetch_addr", mem_addr, 32'h100);
        cycle();
        if_req = 0; mem_rdata = 32'h0050_0093;
        #1 chk("fetch_rdata", if_rdata, 32'h0050_0093);
        chk("fetch_isInst", isInst, 1'b1);
        cycle();

        // Contention: four data grants, then one fetch, repeating
        if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h104; d_addr = 32'h1000;
        for (int k = 0; k < 10; k++) begin
            mem_rdata = $urandom;
            #1 chk("cont_if_gnt", if_gnt, (k % 5) == 4);
            cycle();
        end
        if_req = 0; d_req = 0;
        cycle();

        // Store
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
        #1 chk("store_we", mem_we, 1'b1);
        chk("store_be", mem_be, 4'b0011);
        chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        cycle();
        d_req = 0; d_we = 0;
        #1 chk("store_no_rvalid", d_rvalid, 1'b0);
        cycle();

        // Halt with data pending; fetch frozen, data drains
        if_req = 1; if_addr = 32'h108; d_req = 1; d_addr = 32'h3000; halt_req = 1;
        cycle();
        halt_req = 0;
        #1 chk("halt_halted", halted, 1'b1);
        for (int k = 0; k < 10; k++) begin
            d_req = (k < 3);
            #1 chk("halt_no_fetch", if_gnt, 1'b0);
            chk("halt_drain", d_gnt, k < 3);
            cycle();
        end
        halt_clr = 1;
        cycle();
        halt_clr = 0;
        #1 chk("resume_fetch", if_gnt, 1'b1);
        cycle();
        if_req = 0;
        cycle();

        // Simultaneous halt_req and halt_clr: halt wins
        halt_req = 1; halt_clr = 1;
        cycle();
        halt_req = 0; halt_clr = 0;
        #1 chk("simul_halted", halted, 1'b1);
        cycle();
        halt_clr = 1;
        cycle();
        halt_clr = 0;

        // Randomized traffic; requests held until granted
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 149) == 0);
            halt_req = ($urandom_range(0, 39) == 0);
            halt_clr = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            if (!if_req || last_i || rst) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom;
            end
            if (!d_req || last_d || rst) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1);
                d_be    = $urandom_range(0, 15);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the IF stage (fetch requester) and the MEM stage (load/store requester).
- Grants one access per cycle, returns read data one cycle later to the owning requester, and generates isInst for the control unit.
- Implements the EBREAK halt: fetch grants are frozen while data traffic drains.
- Sits between the pipeline stage registers and the memory macro.

Parameters:
ADDR_W, 32, byte address width of both requesters and the memory port
DATA_W, 32, data width
MAX_DATA_STREAK, 4, max consecutive data grants while a fetch is pending; range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch data valid (registered)
if_rdata  out  DATA_W  instruction word
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_be  in  4  byte enables for stores
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data access accepted this cycle (combinational)
d_rvalid  out  1  load data valid (registered)
d_rdata  out  DATA_W  load data
halt_req  in  1  one-cycle pulse when EBREAK is decoded (loadPC low)
halt_clr  in  1  debugger/resume pulse
halted  out  1  arbiter is in HALT
isInst  out  1  instruction bus valid to the control unit; equals if_rvalid
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous-read data; valid the cycle after a read

Behaviour:
- Reset (async, rst=1):
  - State = RUN, streak = 0, pending = NONE, halted = 0.
  - if_rvalid, d_rvalid and isInst = 0; if_rdata and d_rdata = 0.
  - While rst is high, no grants are issued and mem_en = 0.
  - Any in-flight read is discarded; no rvalid is produced for it after reset deasserts.
- States:
  - RUN → HALT when halt_req = 1.
  - HALT → RUN when halt_clr = 1 and halt_req = 0.
  - Simultaneous halt_req and halt_clr: halt_req wins.
  - halted = (state == HALT), registered.
- Grant, combinational each cycle:
  - Only d_req: d_gnt = 1.
  - Only if_req, and state = RUN: if_gnt = 1.
  - Both, in RUN: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - In HALT: if_gnt = 0 always; data requests are still granted so older stores drain.
  - At most one of if_gnt / d_gnt is high in any cycle.
- Memory drive:
  - On a grant: mem_en = 1, and mem_addr / mem_we / mem_be / mem_wdata are taken from the winner.
  - Fetch: mem_we = 0, mem_be = 4'hF, mem_wdata = 0.
  - No grant: all mem_* = 0.
  - Addresses pass through unmodified; no alignment checking.
- Streak counter (MAX_DATA_STREAK bits wide enough, saturating):
  - Increments on a d_gnt cycle while if_req = 1.
  - Clears on if_gnt, or on any cycle with if_req = 0.
  - Saturates at MAX_DATA_STREAK.
  - Does not count while in HALT.
- Read return, latency exactly 1 cycle:
  - pending register = IF on if_gnt; = D on d_gnt with d_we = 0; otherwise NONE.
  - Next cycle: if_rvalid = (pending == IF) and d_rvalid = (pending == D).
  - The matching rdata register captures mem_rdata; the other rdata output holds its last value.
  - Stores produce no rvalid; d_gnt completes the store.
- isInst = if_rvalid; it is 0 in every cycle without a fresh instruction, which forces the control unit to a bubble.
- Fetch granted in the same cycle halt_req arrives: the fetch completes normally (if_rvalid next cycle). No further fetches are granted until RUN.

Test Plan:
- Reset mid-read: if_gnt in cycle 3, rst asserted in cycle 4 → if_rvalid never rises; all outputs 0; first grant after release issues cleanly.
- Fetch only: if_req=1, if_addr=0x100, mem_rdata=0x00500093 → if_gnt cycle N, mem_addr=0x100, if_rvalid=isInst=1 with if_rdata=0x00500093 at N+1.
- Contention with MAX_DATA_STREAK=4: d_req and if_req held high → d_gnt for 4 cycles, then if_gnt on the 5th, streak resets, and the pattern repeats.
- Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF → mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; no d_rvalid.
- Halt: halt_req pulse with d_req pending → halted=1 next cycle, data still granted, if_gnt=0 for 10 cycles; halt_clr pulse → fetch granted the following cycle.
- Simultaneous halt_req and halt_clr in RUN → state goes to HALT and halted=1.
